ain_debounce: RTL and testbench
===============================

Name: ain_debounce

Overview:
Input conditioner that sits directly upstream of the 2-bit-input Moore state machine and drives its ain bus. It takes raw, asynchronous switch/button levels, synchronises each bit with a 2-flop synchroniser, and debounces each bit independently. A bit is accepted only after it has held a new value for DEBOUNCE consecutive clocks, so the downstream FSM never sees metastable or bouncing inputs.

Parameters:
WIDTH, 2, number of input bits (matches the FSM ain bus).
DEBOUNCE, 4, consecutive synchronised cycles of disagreement required before a bit is accepted; legal range 1..255.
GLITCH_W, 8, width of the glitch counter; used only when GLITCH_COUNT_EN is defined.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
raw_in  input  WIDTH  raw asynchronous input levels.
ain  output  WIDTH  debounced, registered value; feeds FSM ain.
ain_chg  output  1  one-cycle pulse, registered; high in the cycle after any ain bit updates.
busy  output  1  combinational; high while any bit is pending (synchronised value differs from ain).
glitch_cnt  output  GLITCH_W  rejected-glitch count; present only with GLITCH_COUNT_EN.

Behaviour:
- Reset: asynchronous, active-high. While reset is high, s1, s2, ain, all counters, ain_chg and glitch_cnt are 0 and busy is 0. Any pending debounce is discarded. After release, the normal 2+DEBOUNCE delay applies from scratch.
- Synchroniser: on each clock, s1 <= raw_in and s2 <= s1.
- Per-bit state machine, one for each bit i, with a counter cnt[i] wide enough to hold DEBOUNCE-1:
  - STABLE (s2[i]==ain[i]): cnt[i] <= 0.
  - PENDING (s2[i]!=ain[i]), cnt[i] < DEBOUNCE-1: cnt[i] <= cnt[i]+1.
  - PENDING, cnt[i]==DEBOUNCE-1: ain[i] <= s2[i]; cnt[i] <= 0.
  - PENDING -> STABLE with cnt[i]!=0 (s2 returned to ain before acceptance): glitch; cnt[i] <= 0 and ain[i] is unchanged.
- Latency: raw_in first sampled at edge k gives ain updated at edge k+1+DEBOUNCE. For DEBOUNCE=4 this is edge k+5; for DEBOUNCE=1 it is edge k+2.
- Bits are independent:
  - Bits that change together are accepted on the same edge.
  - Staggered changes pass through intermediate values; for example 00->01->11 presents 01 to the FSM for the stagger duration. This is intended.
- ain_chg is set on the edge where any ain bit updates and cleared on the next edge. Multiple bits updating on the same edge produce a single pulse. Back-to-back updates on consecutive edges keep ain_chg high on both.
- busy = OR over i of (s2[i]!=ain[i]). It has no internal register beyond s2 and ain.
- Changes of DEBOUNCE or more cycles are never lost.
- Pulses shorter than DEBOUNCE synchronised cycles are never propagated.
- A pulse shorter than one clock may be missed entirely by the synchroniser. This is acceptable.

Optional Feature:
GLITCH_COUNT_EN
- Defined:
  - glitch_cnt port exists.
  - It increments by 1 on each edge where at least one bit takes the PENDING->STABLE-with-cnt!=0 glitch path. Simultaneous glitches on several bits count as 1.
  - It saturates at 2^GLITCH_W-1 and is cleared only by reset.
- Not defined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
1. raw_in=11 and clocks running, then assert reset asynchronously between edges -> ain=00, ain_chg=0, busy=0 immediately with no clock edge; release reset -> ain=11 exactly 2+DEBOUNCE edges later.
2. DEBOUNCE=4, raw_in 00->11 sampled at edge k and held -> ain=11 at edge k+5; ain_chg high for exactly one cycle after k+5; busy high from after edge k+1 until edge k+5.
3. raw_in bit0 high for 3 cycles then low -> ain stays 00, ain_chg never pulses; glitch_cnt=1 with GLITCH_COUNT_EN.
4. raw_in 00->01 at edge k, 01->11 at edge k+2 -> ain=01 at k+5, ain=11 at k+7; two separate ain_chg pulses.
5. raw_in 00->10, reset pulsed after 2 counting cycles, raw still 10 -> ain stays 00 through reset; ain=10 at 2+DEBOUNCE edges after release.
6. GLITCH_COUNT_EN, GLITCH_W=2, 5 separate 2-cycle glitches on bit1 -> glitch_cnt reads 1,2,3,3,3; ain stays 00 throughout.

Source files
------------

// File: rtl/ain_debounce.sv
// ain_debounce: input conditioner for the FSM ain bus.
// Each raw bit passes through a 2-flop synchroniser and is then debounced
// independently: a bit is accepted only after the synchronised value has
// disagreed with ain for DEBOUNCE consecutive clocks.
// Optional build macro: GLITCH_COUNT_EN adds a saturating glitch_cnt output
// counting clocks on which at least one bit abandoned a pending change.
module ain_debounce #(
    parameter int WIDTH    = 2,
    parameter int DEBOUNCE = 4,
    parameter int GLITCH_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] ain,
    output logic             ain_chg,
    output logic             busy
`ifdef GLITCH_COUNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

    // Counter must hold DEBOUNCE-1; keep at least one bit for DEBOUNCE==1.
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } bit_state_t;

    if (DEBOUNCE < 1 || DEBOUNCE > 255 || GLITCH_W < 1) begin : g_param_check
        $error("ain_debounce: DEBOUNCE must be 1..255 and GLITCH_W >= 1");
    end

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_nxt  [WIDTH];
    logic [WIDTH-1:0] ain_nxt;
    bit_state_t       state    [WIDTH];
`ifdef GLITCH_COUNT_EN
    logic [WIDTH-1:0] glitch_bit;
`endif

    // Two-flop synchroniser for the raw asynchronous levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
        end
    end

    // Per-bit next-state: count disagreement, accept at DEBOUNCE-1, flag glitches.
    always_comb begin
        ain_nxt = ain;
`ifdef GLITCH_COUNT_EN
        glitch_bit = '0;
`endif
        for (int unsigned i = 0; i < WIDTH; i++) begin
            state[i]   = (s2[i] != ain[i]) ? PENDING : STABLE;
            cnt_nxt[i] = '0;
            case (state[i])
                STABLE: begin
`ifdef GLITCH_COUNT_EN
                    // A nonzero count while stable means s2 fell back before acceptance.
                    glitch_bit[i] = (cnt[i] != '0);
`endif
                end
                PENDING: begin
                    if (cnt[i] == CNT_MAX) begin
                        ain_nxt[i] = s2[i];
                    end else begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                default: cnt_nxt[i] = '0;
            endcase
        end
    end

    // Debounce state registers and the one-cycle change pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ain     <= '0;
            ain_chg <= 1'b0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            ain     <= ain_nxt;
            ain_chg <= |(ain_nxt ^ ain);
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

`ifdef GLITCH_COUNT_EN
    // Saturating count of clocks on which any bit took the glitch path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_cnt <= '0;
        end else if ((|glitch_bit) && (glitch_cnt != '1)) begin
            glitch_cnt <= glitch_cnt + 1'b1;
        end
    end
`endif

    // Pending indication straight from the synchronised value and ain.
    always_comb begin
        busy = |(s2 ^ ain);
    end

endmodule

// File: tb/tb_ain_debounce.sv
// tb_ain_debounce: directed and randomized checks of ain_debounce against a
// history-window reference model, for DEBOUNCE=4 and DEBOUNCE=1 instances.
module tb_ain_debounce;

    localparam int W    = 2;
    localparam int D0   = 4;
    localparam int D1   = 1;
    localparam int GW   = 2;
    localparam int GMAX = (1 << GW) - 1;
    localparam int HMAX = 4096;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] raw_in = '0;

    logic [W-1:0] ain0, ain1;
    logic         chg0, chg1;
    logic         busy0, busy1;
`ifdef GLITCH_COUNT_EN
    logic [GW-1:0] gc0, gc1;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state, index 0 = DEBOUNCE 4 instance, 1 = DEBOUNCE 1.
    logic [W-1:0] s1m [2];
    logic [W-1:0] s2m [2];
    logic [W-1:0] am  [2];
    logic         chgm[2];
    int           gcm [2];
    logic [W-1:0] hist[2][HMAX];
    int           hn  [2];

    ain_debounce #(.WIDTH(W), .DEBOUNCE(D0), .GLITCH_W(GW)) u0 (
        .clk(clk), .reset(reset), .raw_in(raw_in),
        .ain(ain0), .ain_chg(chg0), .busy(busy0)
`ifdef GLITCH_COUNT_EN
        , .glitch_cnt(gc0)
`endif
    );

    ain_debounce #(.WIDTH(W), .DEBOUNCE(D1), .GLITCH_W(GW)) u1 (
        .clk(clk), .reset(reset), .raw_in(raw_in),
        .ain(ain1), .ain_chg(chg1), .busy(busy1)
`ifdef GLITCH_COUNT_EN
        , .glitch_cnt(gc1)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (observed running, expected done)");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            s1m[j] = '0; s2m[j] = '0; am[j] = '0;
            chgm[j] = 1'b0; gcm[j] = 0; hn[j] = 0;
        end
    endtask

    // One rising edge: ain bit takes the synchronised value once the last d
    // synchronised samples all differ from it; a glitch is a run of
    // disagreement that ends with the sample returning to ain.
    task automatic model_edge(input logic [W-1:0] r);
        for (int j = 0; j < 2; j++) begin
            int d;
            logic [W-1:0] na;
            logic g;
            d  = (j == 0) ? D0 : D1;
            na = am[j];
            g  = 1'b0;
            if (hn[j] < HMAX) begin
                hist[j][hn[j]] = s2m[j];
                hn[j]++;
            end
            for (int b = 0; b < W; b++) begin
                if (hn[j] >= d) begin
                    logic all_diff;
                    all_diff = 1'b1;
                    for (int k = 1; k <= d; k++)
                        if (hist[j][hn[j]-k][b] == am[j][b]) all_diff = 1'b0;
                    if (all_diff) na[b] = ~am[j][b];
                end
                if (hn[j] >= 2 && hist[j][hn[j]-1][b] == am[j][b] &&
                    hist[j][hn[j]-2][b] != am[j][b])
                    g = 1'b1;
            end
            chgm[j] = (na != am[j]);
            am[j]   = na;
            if (g && gcm[j] < GMAX) gcm[j]++;
            s2m[j] = s1m[j];
            s1m[j] = r;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_ain0"},  32'(ain0),  32'(am[0]));
        chk({tag, "_chg0"},  32'(chg0),  32'(chgm[0]));
        chk({tag, "_busy0"}, 32'(busy0), 32'(|(s2m[0] ^ am[0])));
        chk({tag, "_ain1"},  32'(ain1),  32'(am[1]));
        chk({tag, "_chg1"},  32'(chg1),  32'(chgm[1]));
        chk({tag, "_busy1"}, 32'(busy1), 32'(|(s2m[1] ^ am[1])));
`ifdef GLITCH_COUNT_EN
        chk({tag, "_gc0"}, 32'(gc0), 32'(gcm[0]));
        chk({tag, "_gc1"}, 32'(gc1), 32'(gcm[1]));
`endif
    endtask

    // Drive raw_in away from the edge, clock once, check 1 time unit later.
    task automatic tick(input string tag, input logic [W-1:0] r);
        raw_in = r;
        @(posedge clk);
        if (!reset) model_edge(r);
        #1;
        check_all(tag);
    endtask

    // Assert reset between edges, check immediately, hold, then release.
    task automatic pulse_reset(input string tag, input int hold);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all({tag, "_async"});
        chk({tag, "_async_ain"}, 32'(ain0), 32'h0);
        for (int i = 0; i < hold; i++) tick({tag, "_hold"}, raw_in);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [W-1:0] r;
        model_reset();

        // 1: async reset with raw=11, then 2+DEBOUNCE edge recovery.
        raw_in = 2'b11;
        tick("t1_init", 2'b11);
        #2 reset = 1'b0;
        for (int i = 0; i < 8; i++) tick("t1_run", 2'b11);
        chk("t1_pre_ain", 32'(ain0), 32'h3);
        pulse_reset("t1", 2);
        chk("t1_rst_chg", 32'(chg0), 32'h0);
        chk("t1_rst_busy", 32'(busy0), 32'h0);
        for (int i = 0; i < 5; i++) tick("t1_rel", 2'b11);
        chk("t1_e5_ain", 32'(ain0), 32'h0);
        tick("t1_rel", 2'b11);
        chk("t1_e6_ain", 32'(ain0), 32'h3);

        // 2: 00->11 held, accepted at edge k+5 with a single pulse.
        raw_in = 2'b00;
        pulse_reset("t2", 1);
        for (int i = 0; i < 3; i++) tick("t2_idle", 2'b00);
        tick("t2_k", 2'b11);
        chk("t2_k_busy", 32'(busy0), 32'h0);
        tick("t2_k1", 2'b11);
        chk("t2_k1_busy", 32'(busy0), 32'h1);
        for (int i = 0; i < 3; i++) tick("t2_cnt", 2'b11);
        chk("t2_k4_ain", 32'(ain0), 32'h0);
        chk("t2_k4_busy", 32'(busy0), 32'h1);
        tick("t2_k5", 2'b11);
        chk("t2_k5_ain", 32'(ain0), 32'h3);
        chk("t2_k5_chg", 32'(chg0), 32'h1);
        chk("t2_k5_busy", 32'(busy0), 32'h0);
        tick("t2_k6", 2'b11);
        chk("t2_k6_chg", 32'(chg0), 32'h0);

        // 3: three-cycle pulse on bit0 is rejected.
        raw_in = 2'b00;
        pulse_reset("t3", 1);
        for (int i = 0; i < 3; i++) tick("t3_hi", 2'b01);
        for (int i = 0; i < 6; i++) begin
            tick("t3_lo", 2'b00);
            chk("t3_nochg", 32'(chg0), 32'h0);
        end
        chk("t3_ain", 32'(ain0), 32'h0);
`ifdef GLITCH_COUNT_EN
        chk("t3_gc", 32'(gc0), 32'h1);
`endif

        // 4: staggered 00->01->11 gives two separate updates.
        raw_in = 2'b00;
        pulse_reset("t4", 1);
        tick("t4_k", 2'b01);
        tick("t4_k1", 2'b01);
        tick("t4_k2", 2'b11);
        tick("t4_k3", 2'b11);
        tick("t4_k4", 2'b11);
        chk("t4_k4_ain", 32'(ain0), 32'h0);
        tick("t4_k5", 2'b11);
        chk("t4_k5_ain", 32'(ain0), 32'h1);
        chk("t4_k5_chg", 32'(chg0), 32'h1);
        tick("t4_k6", 2'b11);
        chk("t4_k6_chg", 32'(chg0), 32'h0);
        tick("t4_k7", 2'b11);
        chk("t4_k7_ain", 32'(ain0), 32'h3);
        chk("t4_k7_chg", 32'(chg0), 32'h1);

        // 5: reset mid-count discards the pending change.
        raw_in = 2'b00;
        pulse_reset("t5a", 1);
        for (int i = 0; i < 4; i++) tick("t5_cnt", 2'b10);
        pulse_reset("t5b", 2);
        for (int i = 0; i < 5; i++) tick("t5_rel", 2'b10);
        chk("t5_e5_ain", 32'(ain0), 32'h0);
        tick("t5_rel", 2'b10);
        chk("t5_e6_ain", 32'(ain0), 32'h2);

`ifdef GLITCH_COUNT_EN
        // 6: five 2-cycle glitches on bit1, counter saturates at 3.
        raw_in = 2'b00;
        pulse_reset("t6", 1);
        chk("t6_gc0", 32'(gc0), 32'h0);
        for (int n = 0; n < 5; n++) begin
            tick("t6_hi", 2'b10);
            tick("t6_hi", 2'b10);
            for (int i = 0; i < 5; i++) tick("t6_lo", 2'b00);
            chk("t6_gc", 32'(gc0), 32'((n + 1 > 3) ? 3 : n + 1));
            chk("t6_ain", 32'(ain0), 32'h0);
        end
`endif

        // Randomized: per-bit toggles with random hold times, one mid-run reset.
        raw_in = 2'b00;
        pulse_reset("rnd0", 1);
        r = 2'b00;
        for (int i = 0; i < 500; i++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
            tick("rnd", r);
            if (i == 250) pulse_reset("rnd_mid", $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
